dec_select_sequencer: RTL and testbench

//  Upstream driver for the 3-to-8 enable decoder. Arbitrates a request vector round-robin,

---
 rtl/dec_seq_pkg.sv | 29 ++
 rtl/dec_seq_rr_arb.sv | 42 ++++
 rtl/dec_select_sequencer.sv | 157 +++++++++++++++
 tb/tb_dec_select_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_seq_pkg.sv
// Package: dec_seq_pkg
// Shared types and helpers for the decoder select sequencer.
//   nch_of     : channel count for a given select width (2**n_sel)
//   dec_seq_state_t : sequencer FSM states (IDLE, HOLD, GAP)
//   onehot_of  : expected decoder output for a select code, used by the
//                decoder fault checker and by the bench's decoder model
package dec_seq_pkg;

  // Widest select code the helpers support. Callers narrow the result.
  localparam int SEL_W_MAX = 8;
  localparam int NCH_MAX   = 1 << SEL_W_MAX;

  function automatic int nch_of(input int n_sel);
    return 1 << n_sel;
  endfunction

  // Enumerators carry an ST_ prefix because the top-level GAP parameter
  // would otherwise collide with the GAP state name.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP
  } dec_seq_state_t;

  function automatic logic [NCH_MAX-1:0] onehot_of(input logic [SEL_W_MAX-1:0] sel);
    return NCH_MAX'(1) << sel;
  endfunction

endpackage

// File: rtl/dec_seq_rr_arb.sv
// Module: dec_seq_rr_arb
// Combinational round-robin pick. Searches req starting at last+1 and
// wrapping, returning the first requesting channel.
// Ports:
//   req   in  NCH    per-channel request
//   last  in  N_SEL  most recently granted channel
//   grant out N_SEL  chosen channel (valid when any=1)
//   any   out 1      at least one request present
module dec_seq_rr_arb #(
  parameter int N_SEL = 3
) (
  input  logic [2**N_SEL-1:0] req,
  input  logic [N_SEL-1:0]    last,
  output logic [N_SEL-1:0]    grant,
  output logic                any
);

  localparam int NCH = 2 ** N_SEL;

  logic [N_SEL-1:0] idx;
  logic             found;

  always_comb begin
    // NOTE: every variable gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Offsets 1..NCH; the N_SEL-bit add wraps modulo NCH, so offset NCH
    // lands back on last itself (a lone requester is re-granted).
    for (int i = 1; i <= NCH; i++) begin
      idx = last + N_SEL'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dec_select_sequencer.sv
// Module: dec_select_sequencer
// Upstream driver for a 3-to-8 enable decoder. Grants requesting channels
// round-robin, holds the decoder enable for DWELL cycles per grant, then
// keeps it low for GAP cycles before re-arbitrating. sel only changes on
// the IDLE->HOLD edge, so it is stable whenever en is high.
// Parameters: N_SEL (select width), DWELL (en-high cycles, 1..2**CNT_W-1),
//             GAP (en-low cycles after a dwell, 0 = back-to-back),
//             CNT_W (down-counter width).
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   run        in   1      arbitration allowed while high
//   req        in   NCH    per-channel request, sampled only in IDLE
//   sel        out  N_SEL  decoder select code
//   en         out  1      decoder enable
//   busy       out  1      high in HOLD or GAP
//   slot_done  out  1      one-cycle pulse on the last HOLD cycle
//   y_fb       in   NCH    decoder output fed back to the fault checker
//   fault_err  out  1      sticky decoder mismatch flag
// Build option: define DEC_SEQ_FAULT_CHECK_EN to compare y_fb against the
// expected one-hot decode each cycle; otherwise fault_err is tied low.
// All outputs are registered.
module dec_select_sequencer
  import dec_seq_pkg::*;
#(
  parameter int N_SEL = 3,
  parameter int DWELL = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [2**N_SEL-1:0] req,
  output logic [N_SEL-1:0]    sel,
  output logic                en,
  output logic                busy,
  output logic                slot_done,
  input  logic [2**N_SEL-1:0] y_fb,
  output logic                fault_err
);

  localparam int NCH = nch_of(N_SEL);

  dec_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SEL-1:0] last_q, last_d;
  logic [N_SEL-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             slot_done_q, slot_done_d;
  logic [N_SEL-1:0] grant;
  logic             any;

  dec_seq_rr_arb #(.N_SEL(N_SEL)) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (run && any) begin
          state_d = ST_HOLD;
          sel_d   = grant;
          last_d  = grant;
          cnt_d   = CNT_W'(DWELL - 1);
        end
      end
      ST_HOLD: begin
        // run and req are deliberately ignored here: a started dwell always
        // runs to completion.
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they
    // describe the cycle that follows the edge with no input-to-output path.
    en_d        = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
    slot_done_d = (state_d == ST_HOLD) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= N_SEL'(NCH - 1);
      sel_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign sel       = sel_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign slot_done = slot_done_q;

`ifdef DEC_SEQ_FAULT_CHECK_EN
  // y_fb is the decoder's response to the sel/en currently being driven,
  // so any mismatch is latched one cycle after it appears.
  logic [NCH-1:0] fault_expect;
  logic           fault_err_q;

  assign fault_expect = en_q ? NCH'(onehot_of(SEL_W_MAX'(sel_q))) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_err_q <= 1'b0;
    end else if (y_fb != fault_expect) begin
      fault_err_q <= 1'b1;
    end
  end

  assign fault_err = fault_err_q;
`else
  logic unused_y_fb;
  assign unused_y_fb = ^y_fb;
  assign fault_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dec_select_sequencer.sv
// Directed bench for dec_select_sequencer. Main instance uses default
// parameters (DWELL=4, GAP=1); a second instance uses GAP=0. A behavioural
// decoder closes the y_fb loop, with an optional stuck-at-0 mask.
module tb_dec_select_sequencer;
  import dec_seq_pkg::*;

  localparam int N_SEL = 3;
  localparam int NCH   = 8;

`ifdef DEC_SEQ_FAULT_CHECK_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             run, run_g0;
  logic [NCH-1:0]   req, req_g0;
  logic [NCH-1:0]   stuck_mask;
  logic [N_SEL-1:0] sel, sel_g0;
  logic             en, en_g0;
  logic             busy, busy_g0;
  logic             slot_done, slot_done_g0;
  logic             fault_err, fault_err_g0;
  logic [NCH-1:0]   y_fb, y_fb_g0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Decoder models: one-hot of sel when enabled; stuck_mask forces bits low.
  assign y_fb    = (en ? NCH'(onehot_of(8'(sel))) : '0) & ~stuck_mask;
  assign y_fb_g0 = en_g0 ? NCH'(onehot_of(8'(sel_g0))) : '0;

  dec_select_sequencer #(.N_SEL(3), .DWELL(4), .GAP(1), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .req       (req),
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .slot_done (slot_done),
    .y_fb      (y_fb),
    .fault_err (fault_err)
  );

  dec_select_sequencer #(.N_SEL(3), .DWELL(4), .GAP(0), .CNT_W(8)) dut_g0 (
    .clk       (clk),
    .rst       (rst),
    .run       (run_g0),
    .req       (req_g0),
    .sel       (sel_g0),
    .en        (en_g0),
    .busy      (busy_g0),
    .slot_done (slot_done_g0),
    .y_fb      (y_fb_g0),
    .fault_err (fault_err_g0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; outputs are read 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; req = '0;
    run_g0 = 1'b0; req_g0 = '0; stuck_mask = '0;
    step(2);
    check("rst_sel",       32'(sel),       32'd0);
    check("rst_en",        32'(en),        32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_slot_done", 32'(slot_done), 32'd0);
    check("rst_fault_err", 32'(fault_err), 32'd0);
    rst = 1'b0;

    // 1: single requester ch2; 4 HOLD, slot_done on 4th, 1 GAP, IDLE, regrant
    run = 1'b1; req = 8'h04;
    check("t1_pre_en", 32'(en), 32'd0);
    step(1);
    check("t1_en",   32'(en),        32'd1);
    check("t1_sel",  32'(sel),       32'd2);
    check("t1_busy", 32'(busy),      32'd1);
    check("t1_sd0",  32'(slot_done), 32'd0);
    step(2);
    check("t1_en3",  32'(en),        32'd1);
    check("t1_sd3",  32'(slot_done), 32'd0);
    step(1);
    check("t1_en4",  32'(en),        32'd1);
    check("t1_sd4",  32'(slot_done), 32'd1);
    step(1);
    check("t1_gap_en",   32'(en),        32'd0);
    check("t1_gap_busy", 32'(busy),      32'd1);
    check("t1_gap_sd",   32'(slot_done), 32'd0);
    step(1);
    check("t1_idle_en",   32'(en),   32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    step(1);
    check("t1_regrant_en",  32'(en),  32'd1);
    check("t1_regrant_sel", 32'(sel), 32'd2);

    // 2: all requesters, reset first -> 0,1,...,7,0 every 6 cycles
    rst = 1'b1; req = 8'hFF;
    step(1);
    rst = 1'b0;
    check("t2_rst_en", 32'(en), 32'd0);
    step(1);
    check("t2_first_en",  32'(en),  32'd1);
    check("t2_first_sel", 32'(sel), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(5);
      check("t2_low_en", 32'(en), 32'd0);
      step(1);
      check("t2_rise_en", 32'(en),  32'd1);
      check("t2_sel",     32'(sel), 32'(i % 8));
    end
    check("t2_fault_err", 32'(fault_err), 32'd0);

    // 3: last=0, req=81 -> 7 then 0; drop req mid-HOLD, dwell completes
    req = 8'h81;
    step(5);
    check("t3_low_en", 32'(en), 32'd0);
    step(1);
    check("t3_sel7", 32'(sel), 32'd7);
    step(6);
    check("t3_sel0", 32'(sel), 32'd0);
    check("t3_en0",  32'(en),  32'd1);
    step(1);
    req = 8'h00;
    step(2);
    check("t3_drop_en", 32'(en),        32'd1);
    check("t3_drop_sd", 32'(slot_done), 32'd1);
    step(1);
    check("t3_gap_en",   32'(en),   32'd0);
    check("t3_gap_busy", 32'(busy), 32'd1);
    step(1);
    check("t3_idle_busy", 32'(busy), 32'd0);
    step(3);
    check("t3_nogrant_en",   32'(en),   32'd0);
    check("t3_nogrant_busy", 32'(busy), 32'd0);

    // 4: reset on the 2nd HOLD cycle; next grant restarts search at ch0
    req = 8'h02;
    step(1);
    check("t4_en",  32'(en),  32'd1);
    check("t4_sel", 32'(sel), 32'd1);
    step(1);
    rst = 1'b1;
    step(1);
    check("t4_rst_en",   32'(en),        32'd0);
    check("t4_rst_busy", 32'(busy),      32'd0);
    check("t4_rst_sd",   32'(slot_done), 32'd0);
    rst = 1'b0; req = 8'h06;
    step(1);
    check("t4_regrant_sel", 32'(sel),       32'd1);
    check("t4_regrant_en",  32'(en),        32'd1);
    check("t4_regrant_sd",  32'(slot_done), 32'd0);
    run = 1'b0;
    step(6);
    check("t4_stop_en",   32'(en),   32'd0);
    check("t4_stop_busy", 32'(busy), 32'd0);

    // 5: GAP=0 instance, req=03 -> en low for 1 cycle, sel alternates 0/1
    run_g0 = 1'b1; req_g0 = 8'h03;
    step(1);
    check("t5_en",  32'(en_g0),  32'd1);
    check("t5_sel", 32'(sel_g0), 32'd0);
    step(3);
    check("t5_sd", 32'(slot_done_g0), 32'd1);
    step(1);
    check("t5_low_en",   32'(en_g0),   32'd0);
    check("t5_low_busy", 32'(busy_g0), 32'd0);
    step(1);
    check("t5_en1",  32'(en_g0),  32'd1);
    check("t5_sel1", 32'(sel_g0), 32'd1);
    step(4);
    check("t5_low2_en", 32'(en_g0), 32'd0);
    step(1);
    check("t5_en2",  32'(en_g0),  32'd1);
    check("t5_sel2", 32'(sel_g0), 32'd0);
    check("t5_fault_err", 32'(fault_err_g0), 32'd0);
    run_g0 = 1'b0; req_g0 = '0;

    // 6: decoder Y[3] stuck-at-0, grant ch3
    rst = 1'b1;
    step(1);
    rst = 1'b0; stuck_mask = 8'h08; req = 8'h08; run = 1'b1;
    step(1);
    check("t6_sel",       32'(sel),       32'd3);
    check("t6_en",        32'(en),        32'd1);
    check("t6_fault_pre", 32'(fault_err), 32'd0);
    step(1);
    check("t6_fault", 32'(fault_err), 32'(FAULT_EXP));
    stuck_mask = '0; run = 1'b0;
    step(8);
    check("t6_fault_sticky", 32'(fault_err), 32'(FAULT_EXP));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_fault_cleared", 32'(fault_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
